alu_rs_scheduler: RTL
=====================

# alu_rs_scheduler

Reservation-station scheduler for the integer ALU. Holds up to ENTRIES dispatched ALU operations, captures missing operands from the two result broadcast buses, and issues at most one ready operation per cycle, with registered outputs, into the ALU's RsvStation input. It sits between the dispatch stage and the ALU, whose result path feeds the ReorderBuffer.

## Interface
- ENTRIES, 8, number of station slots (power of two, 2..16)
- OP_W, 6, width of OP_ID encoding (`OpIdBus`)
- ROB_W, 4, width of ROB tag (`ROBIDBus`)
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low = freeze
- flush  in  1  mispredict clear
- disp_valid  in  1  dispatch request
- disp_op  in  OP_W  operation ID
- disp_pc  in  32  instruction PC
- disp_imm  in  32  immediate
- disp_rob_id  in  ROB_W  destination ROB tag
- disp_vj / disp_vk  in  32  operand values
- disp_qj / disp_qk  in  ROB_W  producer tags
- disp_j_wait / disp_k_wait  in  1  operand not yet available (tag is valid)
- disp_full  out  1  all entries busy (combinational from state)
- cdb_alu_valid, cdb_alu_rob_id[ROB_W], cdb_alu_value[32]  in  ALU result broadcast
- cdb_lsb_valid, cdb_lsb_rob_id[ROB_W], cdb_lsb_value[32]  in  load/store result broadcast
- alu_valid  out  1  issue strobe (maps to RS_input_valid)
- alu_op[OP_W], alu_pc[32], alu_rs1[32], alu_rs2[32], alu_imm[32], alu_rob_id[ROB_W]  out  issued payload

## Operation
- Entry state: busy, op, pc, imm, rob_id, vj, qj, j_wait, vk, qk, k_wait.
- Dispatch: when disp_valid && !disp_full, write the lowest-index free entry. Dispatch while full is dropped silently; the dispatch side must not send then.
- Dispatch bypass: if a broadcast in the same cycle matches disp_qj or disp_qk on a waiting operand, store the broadcast value with wait = 0.
- Wakeup: every busy entry with j_wait && qj == broadcast tag captures the value and clears j_wait; same for k. Both buses are checked in parallel. If both buses carry the same tag, the ALU bus wins.
- Ready = busy && !j_wait && !k_wait, evaluated from registered state only. An operand woken at edge N makes the entry eligible at edge N+1.
- Select: the lowest-index ready entry. On the edge, register its payload to the alu_* outputs (rs1 = vj, rs2 = vk), set alu_valid = 1, and clear its busy bit. If nothing is ready, alu_valid = 0 and the payload outputs hold their last values.
- Flush (rdy high): clear all busy bits and drive alu_valid = 0 at the edge. Flush has priority over dispatch, wakeup and issue in the same cycle.
- rdy low: no state changes (dispatch, wakeup, issue and flush all ignored); alu_valid is registered 0 so the ALU cannot double-issue. Producers do not broadcast while rdy is low.
- Reset (rst low, any time including mid-operation): all busy = 0, alu_valid = 0, all alu_* payload outputs = 0. disp_full therefore reads 0.

## Timing
- Dispatch with both operands ready at edge N: alu_valid = 1 in the cycle after edge N+1 (two-edge minimum latency).
- Dispatch with an operand woken by a same-cycle broadcast at edge N: same latency as above.
- Throughput: one issue per cycle.
- Dispatch and issue in the same cycle: the free slot is computed from pre-edge state, so a slot freed by issue at edge N is reusable from edge N+1.
- disp_full is combinational from the busy bits; it deasserts in the cycle after the edge that frees a slot.
- The ALU registers its result one edge after alu_valid.

## Structure
- Shared package (defines): `OpIdBus`, `ROBIDBus`, `DataWidth`, `True`/`False`, and the OP_ID constants.
- Sub-module alu_rs_pick: parameterised lowest-index priority encoder returning found + index. It is instantiated twice, once for the free slot and once for the ready slot.

## Test plan
- Reset then dispatch ADD (vj = 5, vk = 7, no waits, rob 3) -> alu_valid after 2 edges with rs1 = 5, rs2 = 7, rob_id = 3; entry freed.
- Dispatch with qj = 4 waiting; cdb_lsb broadcast rob 4 value 0x1234 two cycles later -> issue the edge after the broadcast with rs1 = 0x1234.
- Dispatch waiting on qj = 2 in the same cycle as cdb_alu broadcast rob 2 value 9 -> captured by bypass; issue 2 edges later with rs1 = 9.
- Fill 8 entries waiting on tag 1 -> disp_full = 1 and a 9th dispatch is dropped. Broadcast tag 1 -> issues in index order 0..7 on 8 consecutive cycles; disp_full drops after the first issue.
- With entries ready, pulse flush together with a dispatch -> alu_valid = 0 next cycle and no entries remain; also pulse rst low mid-issue -> all outputs are 0 immediately.
- Hold rdy low for 3 cycles while an entry is ready -> alu_valid = 0 throughout; issue occurs on the first edge with rdy high.

Source files
------------

// File: rtl/alu_rs_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_scheduler_pkg
// Description : Shared widths, bus types, boolean constants and ALU OP_ID
//               encodings used by the ALU reservation-station scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rs_scheduler_pkg;

  localparam int OP_ID_W  = 6;
  localparam int ROB_ID_W = 4;
  localparam int DataWidth = 32;

  typedef logic [OP_ID_W-1:0]  OpIdBus;
  typedef logic [ROB_ID_W-1:0] ROBIDBus;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Integer ALU operation identifiers
  localparam OpIdBus OP_NOP = 6'd0;
  localparam OpIdBus OP_ADD = 6'd1;
  localparam OpIdBus OP_SUB = 6'd2;
  localparam OpIdBus OP_AND = 6'd3;
  localparam OpIdBus OP_OR  = 6'd4;
  localparam OpIdBus OP_XOR = 6'd5;
  localparam OpIdBus OP_SLL = 6'd6;
  localparam OpIdBus OP_SRL = 6'd7;
  localparam OpIdBus OP_SRA = 6'd8;
  localparam OpIdBus OP_SLT = 6'd9;

endpackage
`default_nettype wire

// File: rtl/alu_rs_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_scheduler_if
// Description : Dispatch, result-broadcast and issue signals of the ALU
//               reservation station. slave = station view, master = the
//               surrounding pipeline (dispatch, producers, ALU).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rs_scheduler_if
  import alu_rs_scheduler_pkg::*;
#(
  parameter int OP_W  = OP_ID_W,
  parameter int ROB_W = ROB_ID_W
);

  logic                 disp_valid;
  logic [OP_W-1:0]      disp_op;
  logic [DataWidth-1:0] disp_pc;
  logic [DataWidth-1:0] disp_imm;
  logic [ROB_W-1:0]     disp_rob_id;
  logic [DataWidth-1:0] disp_vj;
  logic [DataWidth-1:0] disp_vk;
  logic [ROB_W-1:0]     disp_qj;
  logic [ROB_W-1:0]     disp_qk;
  logic                 disp_j_wait;
  logic                 disp_k_wait;
  logic                 disp_full;

  logic                 cdb_alu_valid;
  logic [ROB_W-1:0]     cdb_alu_rob_id;
  logic [DataWidth-1:0] cdb_alu_value;
  logic                 cdb_lsb_valid;
  logic [ROB_W-1:0]     cdb_lsb_rob_id;
  logic [DataWidth-1:0] cdb_lsb_value;

  logic                 alu_valid;
  logic [OP_W-1:0]      alu_op;
  logic [DataWidth-1:0] alu_pc;
  logic [DataWidth-1:0] alu_rs1;
  logic [DataWidth-1:0] alu_rs2;
  logic [DataWidth-1:0] alu_imm;
  logic [ROB_W-1:0]     alu_rob_id;

  modport slave (
    input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob_id,
           disp_vj, disp_vk, disp_qj, disp_qk, disp_j_wait, disp_k_wait,
    output disp_full,
    input  cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    output alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );

  modport master (
    output disp_valid, disp_op, disp_pc, disp_imm, disp_rob_id,
           disp_vj, disp_vk, disp_qj, disp_qk, disp_j_wait, disp_k_wait,
    input  disp_full,
    output cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    input  alu_valid, alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id
  );

endinterface
`default_nettype wire

// File: rtl/alu_rs_scheduler_pick.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_pick
// Description : Lowest-index priority encoder. found = any request set,
//               idx = position of the lowest set request (0 when none).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs_scheduler
// Description : ALU reservation station. Holds up to ENTRIES dispatched ops,
//               captures operands from the ALU and LSB result buses, and
//               issues the lowest-index ready op per cycle through
//               registered alu_* outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int OP_W    = OP_ID_W,
  parameter int ROB_W   = ROB_ID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  alu_rs_scheduler_if.slave   bus
);

  localparam int IW = $clog2(ENTRIES);

  // Station entry state
  logic [ENTRIES-1:0]   r_busy;
  logic [ENTRIES-1:0]   r_jw;
  logic [ENTRIES-1:0]   r_kw;
  logic [OP_W-1:0]      r_op  [ENTRIES];
  logic [DataWidth-1:0] r_pc  [ENTRIES];
  logic [DataWidth-1:0] r_imm [ENTRIES];
  logic [ROB_W-1:0]     r_rob [ENTRIES];
  logic [DataWidth-1:0] r_vj  [ENTRIES];
  logic [DataWidth-1:0] r_vk  [ENTRIES];
  logic [ROB_W-1:0]     r_qj  [ENTRIES];
  logic [ROB_W-1:0]     r_qk  [ENTRIES];

  // Registered issue payload
  logic                 r_alu_valid;
  logic [OP_W-1:0]      r_alu_op;
  logic [DataWidth-1:0] r_alu_pc;
  logic [DataWidth-1:0] r_alu_rs1;
  logic [DataWidth-1:0] r_alu_rs2;
  logic [DataWidth-1:0] r_alu_imm;
  logic [ROB_W-1:0]     r_alu_rob;

  logic [ENTRIES-1:0]   w_ready;
  logic                 w_free_found;
  logic [IW-1:0]        w_free_idx;
  logic                 w_rdy_found;
  logic [IW-1:0]        w_rdy_idx;
  logic [DataWidth-1:0] w_dvj;
  logic [DataWidth-1:0] w_dvk;
  logic                 w_djw;
  logic                 w_dkw;

  // Readiness comes from registered state only, so wakeups issue one edge later
  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ready
      assign w_ready[g] = r_busy[g] & ~r_jw[g] & ~r_kw[g];
    end
  endgenerate

  alu_rs_pick #(.N(ENTRIES), .IW(IW)) u_pick_free (
    .req   (~r_busy),
    .found (w_free_found),
    .idx   (w_free_idx)
  );

  alu_rs_pick #(.N(ENTRIES), .IW(IW)) u_pick_ready (
    .req   (w_ready),
    .found (w_rdy_found),
    .idx   (w_rdy_idx)
  );

  assign bus.disp_full  = &r_busy;
  assign bus.alu_valid  = r_alu_valid;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_pc     = r_alu_pc;
  assign bus.alu_rs1    = r_alu_rs1;
  assign bus.alu_rs2    = r_alu_rs2;
  assign bus.alu_imm    = r_alu_imm;
  assign bus.alu_rob_id = r_alu_rob;

  // Dispatch bypass: a same-cycle broadcast fills a waiting operand; ALU bus wins
  always_comb begin
    w_dvj = bus.disp_vj;
    w_djw = bus.disp_j_wait;
    w_dvk = bus.disp_vk;
    w_dkw = bus.disp_k_wait;
    if (bus.disp_j_wait) begin
      if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.disp_qj) begin
        w_dvj = bus.cdb_alu_value;
        w_djw = False;
      end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.disp_qj) begin
        w_dvj = bus.cdb_lsb_value;
        w_djw = False;
      end
    end
    if (bus.disp_k_wait) begin
      if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.disp_qk) begin
        w_dvk = bus.cdb_alu_value;
        w_dkw = False;
      end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.disp_qk) begin
        w_dvk = bus.cdb_lsb_value;
        w_dkw = False;
      end
    end
  end

  // Entry update (wakeup, issue, dispatch) and registered issue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= '0;
      r_jw        <= '0;
      r_kw        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_op[i]  <= '0;
        r_pc[i]  <= '0;
        r_imm[i] <= '0;
        r_rob[i] <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
      end
      r_alu_valid <= False;
      r_alu_op    <= '0;
      r_alu_pc    <= '0;
      r_alu_rs1   <= '0;
      r_alu_rs2   <= '0;
      r_alu_imm   <= '0;
      r_alu_rob   <= '0;
    end else if (rdy) begin
      r_alu_valid <= False;
      if (flush) begin
        r_busy <= '0;
      end else begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (r_busy[i] && r_jw[i]) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == r_qj[i]) begin
              r_vj[i] <= bus.cdb_alu_value;
              r_jw[i] <= False;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == r_qj[i]) begin
              r_vj[i] <= bus.cdb_lsb_value;
              r_jw[i] <= False;
            end
          end
          if (r_busy[i] && r_kw[i]) begin
            if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == r_qk[i]) begin
              r_vk[i] <= bus.cdb_alu_value;
              r_kw[i] <= False;
            end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == r_qk[i]) begin
              r_vk[i] <= bus.cdb_lsb_value;
              r_kw[i] <= False;
            end
          end
        end
        // Issued slot is busy, dispatch slot is free: they never collide
        if (w_rdy_found) begin
          r_busy[w_rdy_idx] <= False;
          r_alu_valid       <= True;
          r_alu_op          <= r_op[w_rdy_idx];
          r_alu_pc          <= r_pc[w_rdy_idx];
          r_alu_rs1         <= r_vj[w_rdy_idx];
          r_alu_rs2         <= r_vk[w_rdy_idx];
          r_alu_imm         <= r_imm[w_rdy_idx];
          r_alu_rob         <= r_rob[w_rdy_idx];
        end
        if (bus.disp_valid && w_free_found) begin
          r_busy[w_free_idx] <= True;
          r_op[w_free_idx]   <= bus.disp_op;
          r_pc[w_free_idx]   <= bus.disp_pc;
          r_imm[w_free_idx]  <= bus.disp_imm;
          r_rob[w_free_idx]  <= bus.disp_rob_id;
          r_vj[w_free_idx]   <= w_dvj;
          r_vk[w_free_idx]   <= w_dvk;
          r_qj[w_free_idx]   <= bus.disp_qj;
          r_qk[w_free_idx]   <= bus.disp_qk;
          r_jw[w_free_idx]   <= w_djw;
          r_kw[w_free_idx]   <= w_dkw;
        end
      end
    end else begin
      r_alu_valid <= False;
    end
  end

endmodule
`default_nettype wire
